// File: rtl/pi_uart_bridge.sv
// PI bus master fed by UART bytes: decodes 1/2-byte command frames into
// single-cycle PI write/read strobes and returns read data as one tx byte.
module pi_uart_bridge #(
    parameter int NUM_BLK = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [NUM_BLK-1:0] pi_blk_sel,
    output logic [3:0]         pi_addr,
    output logic               pi_wr_en,
    output logic               pi_rd_en,
    output logic [7:0]         pi_wr_data,
    input  logic [7:0]         pi_rd_data,
    output logic               busy,
    output logic               cmd_err,
    output logic               overrun,
    input  logic               clr_flags
);

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_STB, RD_STB, RD_SEND} state_t;

    state_t      state;
    logic [1:0]  rst_sync;
    logic        rst_int;
    logic [2:0]  blk_idx;
    logic [15:0] tmo_cnt;
    logic        idx_ok;
    logic        tmo_hit;
    logic        err_set;
    logic        ovr_set;

    function automatic logic blk_ok(input logic [2:0] idx);
        return ({1'b0, idx} < 4'(NUM_BLK));
    endfunction

    function automatic logic [NUM_BLK-1:0] blk_onehot(input logic [2:0] idx);
        return blk_ok(idx) ? (NUM_BLK'(1) << idx) : '0;
    endfunction

    // Reset asserts immediately but releases two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int = rst_sync[1];

    assign busy = (state != IDLE);

    always_comb begin
        idx_ok  = blk_ok(blk_idx);
        tmo_hit = (state == WR_DATA) && !rx_valid && (tmo_cnt == 16'(TIMEOUT - 1));
        err_set = tmo_hit || (((state == WR_STB) || (state == RD_STB)) && !idx_ok);
        ovr_set = rx_valid && ((state == WR_STB) || (state == RD_STB) || (state == RD_SEND));
    end

    // Strobes and select are scheduled one edge ahead so they are registered
    // and land exactly in the WR_STB / RD_STB cycle.
    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            state      <= IDLE;
            blk_idx    <= '0;
            tmo_cnt    <= '0;
            pi_blk_sel <= '0;
            pi_addr    <= '0;
            pi_wr_en   <= 1'b0;
            pi_rd_en   <= 1'b0;
            pi_wr_data <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            cmd_err    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            pi_wr_en   <= 1'b0;
            pi_rd_en   <= 1'b0;
            pi_blk_sel <= '0;
            cmd_err    <= (cmd_err & ~clr_flags) | err_set;
            overrun    <= (overrun & ~clr_flags) | ovr_set;
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        blk_idx <= rx_data[6:4];
                        pi_addr <= rx_data[3:0];
                        if (rx_data[7]) begin
                            tmo_cnt <= '0;
                            state   <= WR_DATA;
                        end else begin
                            pi_rd_en   <= blk_ok(rx_data[6:4]);
                            pi_blk_sel <= blk_onehot(rx_data[6:4]);
                            state      <= RD_STB;
                        end
                    end
                end
                WR_DATA: begin
                    if (rx_valid) begin
                        pi_wr_data <= rx_data;
                        pi_wr_en   <= idx_ok;
                        pi_blk_sel <= blk_onehot(blk_idx);
                        state      <= WR_STB;
                    end else if (tmo_hit) begin
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                WR_STB: state <= IDLE;
                RD_STB: begin
                    tx_data  <= idx_ok ? pi_rd_data : 8'h00;
                    tx_valid <= 1'b1;
                    state    <= RD_SEND;
                end
                RD_SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pi_uart_bridge.sv
// Scoreboard bench for pi_uart_bridge (NUM_BLK=4, TIMEOUT=16): drivers push
// expected PI/tx events with their due cycle; a negedge monitor pops and compares.
module tb_pi_uart_bridge;

    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic [NB-1:0] pi_blk_sel;
    logic [3:0]    pi_addr;
    logic          pi_wr_en;
    logic          pi_rd_en;
    logic [7:0]    pi_wr_data;
    logic [7:0]    pi_rd_data;
    logic          busy;
    logic          cmd_err;
    logic          overrun;
    logic          clr_flags = 1'b0;
    logic [7:0]    rd_stub = 8'h00;

    pi_uart_bridge #(.NUM_BLK(NB), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .pi_blk_sel(pi_blk_sel), .pi_addr(pi_addr),
        .pi_wr_en(pi_wr_en), .pi_rd_en(pi_rd_en),
        .pi_wr_data(pi_wr_data), .pi_rd_data(pi_rd_data),
        .busy(busy), .cmd_err(cmd_err), .overrun(overrun), .clr_flags(clr_flags)
    );

    // Register-block stub: only meaningful during the read strobe.
    assign pi_rd_data = pi_rd_en ? rd_stub : 8'hEE;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event encoding: {kind, sel, addr, data}; kind 1=write, 2=read strobe, 3=tx byte.
    logic [17:0] exp_q[$];
    int          exp_cyc_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [17:0] mon_act;
    logic [17:0] mon_exp;
    int          mon_cyc;

    function automatic logic [17:0] ev(input logic [1:0] k, input logic [3:0] s,
                                       input logic [3:0] a, input logic [7:0] d);
        return {k, s, a, d};
    endfunction

    task automatic expect_ev(input logic [17:0] e, input int c);
        exp_q.push_back(e);
        exp_cyc_q.push_back(c);
    endtask

    always @(negedge clk) begin
        if (pi_wr_en || pi_rd_en || (tx_valid && tx_ready)) begin
            if (pi_wr_en)      mon_act = ev(2'd1, pi_blk_sel, pi_addr, pi_wr_data);
            else if (pi_rd_en) mon_act = ev(2'd2, pi_blk_sel, pi_addr, 8'h00);
            else               mon_act = ev(2'd3, 4'h0, 4'h0, tx_data);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event got=%h at cycle %0d, none expected", mon_act, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_cyc = exp_cyc_q.pop_front();
                if (mon_act !== mon_exp || (mon_cyc >= 0 && mon_cyc != cyc)) begin
                    n_err++;
                    $display("FAIL event got=%h@%0d want=%h@%0d", mon_act, cyc, mon_exp, mon_cyc);
                end
            end
        end else if (pi_blk_sel !== '0) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_sel got=%h want=0 at cycle %0d", pi_blk_sel, cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one rx byte; c returns the cycle in which rx_valid was high.
    task automatic send(input logic [7:0] b, output int c);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        c        = cyc;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic clear_flags();
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        check("flags_cleared", 32'({cmd_err, overrun}), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"},   32'(pi_blk_sel), 32'd0);
        check({tag, "_addr"},  32'(pi_addr), 32'd0);
        check({tag, "_wr_en"}, 32'(pi_wr_en), 32'd0);
        check({tag, "_rd_en"}, 32'(pi_rd_en), 32'd0);
        check({tag, "_wdata"}, 32'(pi_wr_data), 32'd0);
        check({tag, "_tdata"}, 32'(tx_data), 32'd0);
        check({tag, "_tvalid"},32'(tx_valid), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_flags"}, 32'({cmd_err, overrun}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int m;
        tick(1);
        check_reset_outputs("reset");
        tick(2);
        rst_n = 1'b1;
        tick(4);
        check_reset_outputs("post_reset");

        // Writes: strobe exactly one cycle after the data byte.
        send(8'h91, c);
        check("wr_data_busy", 32'(busy), 32'd1);
        send(8'h5A, m);
        expect_ev(ev(2'd1, 4'h2, 4'h1, 8'h5A), m + 1);
        tick(1);
        check("wr_idle_m2", 32'(busy), 32'd0);
        send(8'hB7, c);
        send(8'hC3, m);
        expect_ev(ev(2'd1, 4'h8, 4'h7, 8'hC3), m + 1);

        // Read with a stalled transmitter: offer must stay stable.
        tx_ready = 1'b0;
        rd_stub  = 8'h05;
        send(8'h00, c);
        expect_ev(ev(2'd2, 4'h1, 4'h0, 8'h00), c + 1);
        expect_ev(ev(2'd3, 4'h0, 4'h0, 8'h05), -1);
        tick(1);
        check("rd_tvalid_n2", 32'(tx_valid), 32'd1);
        check("rd_tdata_n2", 32'(tx_data), 32'h05);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("rd_stall_hold", 32'({tx_valid, tx_data}), 32'h105);
        end
        tx_ready = 1'b1;
        tick(1);
        check("rd_stall_done", 32'({busy, tx_valid}), 32'd0);

        // Read with tx_ready high: IDLE at N+3.
        rd_stub = 8'hA7;
        send(8'h2C, c);
        expect_ev(ev(2'd2, 4'h4, 4'hC, 8'h00), c + 1);
        expect_ev(ev(2'd3, 4'h0, 4'h0, 8'hA7), c + 2);
        tick(1);
        check("rd_busy_n2", 32'(busy), 32'd1);
        tick(1);
        check("rd_idle_n3", 32'(busy), 32'd0);

        // Invalid block on read: no strobe, zero byte, error flag.
        rd_stub = 8'h66;
        send(8'h50, c);
        expect_ev(ev(2'd3, 4'h0, 4'h0, 8'h00), c + 2);
        tick(2);
        check("bad_rd_err", 32'({busy, cmd_err}), 32'd1);
        clear_flags();

        // Invalid block on write: no strobe, error flag.
        send(8'hE3, c);
        send(8'h11, m);
        tick(1);
        check("bad_wr_err", 32'({busy, cmd_err}), 32'd1);
        clear_flags();

        // Write timeout after 16 idle cycles in WR_DATA.
        send(8'h82, c);
        tick(c + 16 - cyc);
        check("tmo_busy_c16", 32'({busy, cmd_err}), 32'h2);
        tick(1);
        check("tmo_idle_c17", 32'({busy, cmd_err}), 32'h1);
        rd_stub = 8'h3D;
        send(8'h13, c);
        expect_ev(ev(2'd2, 4'h2, 4'h3, 8'h00), c + 1);
        expect_ev(ev(2'd3, 4'h0, 4'h0, 8'h3D), c + 2);
        tick(2);
        check("tmo_next_read_idle", 32'(busy), 32'd0);
        clear_flags();

        // Byte during RD_SEND is dropped and flagged; response untouched.
        tx_ready = 1'b0;
        rd_stub  = 8'h3C;
        send(8'h01, c);
        expect_ev(ev(2'd2, 4'h1, 4'h1, 8'h00), c + 1);
        expect_ev(ev(2'd3, 4'h0, 4'h0, 8'h3C), -1);
        tick(1);
        send(8'h91, m);
        check("ovr_flag", 32'({overrun, cmd_err}), 32'h2);
        check("ovr_offer", 32'({busy, tx_valid, tx_data}), 32'h33C);
        tx_ready = 1'b1;
        tick(1);
        check("ovr_done", 32'({busy, overrun}), 32'h1);
        clear_flags();

        // Reset in WR_DATA aborts the write.
        send(8'h91, c);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("rst_wr");
        tick(2);
        rst_n = 1'b1;
        tick(6);
        check("rst_wr_after", 32'({busy, pi_wr_en}), 32'd0);

        // Reset in RD_SEND drops the pending offer.
        tx_ready = 1'b0;
        rd_stub  = 8'h77;
        send(8'h02, c);
        expect_ev(ev(2'd2, 4'h1, 4'h2, 8'h00), c + 1);
        tick(1);
        check("rst_rd_offer", 32'({tx_valid, tx_data}), 32'h177);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("rst_rd");
        tx_ready = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(6);
        check("rst_rd_after", 32'({busy, tx_valid}), 32'd0);

        tick(2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
